mem2_stage: RTL
===============

# mem2_stage

MEM2 pipeline stage, directly upstream of the WB stage. It latches the MEM-stage bundle, waits for the DCache load response, and aligns and extends the load data. It forms `MEM2_Result` and drives the MEM2→WB bus. It raises `MEM2_LoadStall` to freeze the pipe while a load response is outstanding, and it drains responses that belong to flushed loads.

## Interface
- Parameters: none.
- `clk` in 1: pipeline clock.
- `rst` in 1: synchronous, active-high reset.
- `MEM2_Flush` in 1: clear the stage register (insert a bubble).
- `MEM2_Wr` in 1: stage register write enable; 0 holds the current contents.
- `MEM_PC`, `MEM_Instr`, `MEM_ALUOut`, `MEM_OutB` in 32 each: MEM-stage bundle. `ALUOut` carries the load address; `OutB` carries the old rt value.
- `MEM_WbSel` in 2: result select.
- `MEM_Dst` in 5: destination register.
- `MEM_RegsWrType` in RegsWrType: write-enable bundle.
- `MEM_LoadType` in 3: load encoding. 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, 7 none.
- `MEM_LoadReq` in 1: MEM issued a DCache read for this instruction.
- `DCache_rvalid` in 1: single-cycle read-data valid pulse.
- `DCache_rdata` in 32: read data, valid with `DCache_rvalid`.
- `MEM2_PC`, `MEM2_Instr`, `MEM2_OutB` out 32: registered copies of the MEM bundle.
- `MEM2_WbSel` out 2, `MEM2_Dst` out 5, `MEM2_RegsWrType` out RegsWrType: registered copies.
- `MEM2_DMOut` out 32: aligned and extended load data.
- `MEM2_Result` out 32: write-back value.
- `MEM2_LoadStall` out 1: load response outstanding; the pipeline must not advance.

## Operation
- **Stage register** (PC, Instr, ALUOut, OutB, WbSel, Dst, RegsWrType, LoadType, LoadReq):
  - `rst` or `MEM2_Flush` → all fields 0.
  - Else `MEM2_Wr` → load the MEM bundle.
  - Else hold.
  - Flush has priority over Wr.
- **FSM states:** IDLE, WAIT, HELD, DRAIN.
  - IDLE/HELD, register loads with `MEM_LoadReq`=1 → WAIT.
  - IDLE/HELD, register loads with `MEM_LoadReq`=0 → IDLE.
  - IDLE/HELD, no load → stay.
  - WAIT with `DCache_rvalid` → capture `DCache_rdata` into the 32-bit buffer → HELD.
  - WAIT, no rvalid → stay.
  - WAIT + `MEM2_Flush` with no rvalid → DRAIN. The response belongs to a killed load.
  - WAIT + `MEM2_Flush` with rvalid in the same cycle → IDLE; the data is dropped.
  - DRAIN with `DCache_rvalid` → discard the data → IDLE.
  - Flush in DRAIN → stay in DRAIN.
  - Any state + `rst` → IDLE, buffer 0.
  - `DCache_rvalid` in IDLE or HELD is ignored.
- **`MEM2_LoadStall`** = 1 in WAIT, and in DRAIN (one outstanding read per port). It is combinational from state only.
- **Load extraction:** little-endian; a = ALUOut[1:0]; B = buffer byte a; H = buffer halfword a[1]; O = OutB.
  - LW: whole word.
  - LB: sext(B). LBU: zext(B).
  - LH: sext(H). LHU: zext(H).
  - LWL, a=0: {buf[7:0], O[23:0]}.
  - LWL, a=1: {buf[15:0], O[15:0]}.
  - LWL, a=2: {buf[23:0], O[7:0]}.
  - LWL, a=3: buf.
  - LWR, a=0: buf.
  - LWR, a=1: {O[31:24], buf[31:8]}.
  - LWR, a=2: {O[31:16], buf[31:16]}.
  - LWR, a=3: {O[31:8], buf[31:24]}.
  - LoadType 7 → DMOut = buffer.
- **`MEM2_Result`** by WbSel:
  - 0: PC+8, modulo 2^32.
  - 1: ALUOut.
  - 2: OutB.
  - 3: DMOut.
- Misaligned LH/LW addresses are caught by the exception unit upstream. This block uses only a[1] for halfwords and ignores a for LW.

## Timing
- **Reset values:**
  - All registered outputs 0.
  - `MEM2_LoadStall` 0.
  - `MEM2_DMOut` 0.
  - `MEM2_Result` 32'h0000_0008 (WbSel=0, PC=0).
- **Non-load instruction:** outputs valid the cycle after capture (zero added latency).
- **Load:** `MEM2_Result` is final the cycle after `DCache_rvalid` (state HELD).
  - During WAIT, `MEM2_DMOut` and `MEM2_Result` show stale buffer data.
  - The controller must hold `MEM2_Wr`=0 and keep WB from capturing while stalled.
- **`DCache_rvalid`:** earliest one cycle after the load enters MEM2; latency is unbounded.
- **Back-to-back loads:**
  - HELD with `MEM2_Wr`=1 and a new load → WAIT next cycle.
  - The old buffer value stays visible only until the new capture.

## Test plan
- **Reset:** assert `rst` 2 cycles → all outputs 0, `MEM2_Result`=8, stall 0, state IDLE.
- **ALU op:** PC=0x80001000, WbSel=1, ALUOut=0x1234 → next cycle `MEM2_Result`=0x1234, stall 0.
- **LB latency:** ALUOut=…02, LoadType=1, LoadReq=1; rvalid 3 cycles later with rdata=0x11_80_22_33:
  - Stall is 1 for exactly those 3 cycles.
  - Then `MEM2_DMOut`=0xFFFFFF80.
- **LWL/LWR:** OutB=0xAABBCCDD, rdata=0x11223344.
  - LWL a=1 → 0x3344CCDD.
  - LWR a=2 → 0xAABB1122.
  - LHU a=2 → 0x00001122.
- **Flush mid-load:** flush in WAIT, then a new ALU op arrives, rvalid 2 cycles later:
  - DRAIN keeps the stall high until rvalid.
  - The rdata never appears on DMOut; the FSM returns to IDLE.
- **Simultaneous events:** Flush with Wr=1 → register cleared; rvalid in the same cycle as the WAIT flush → IDLE, no DRAIN.

Source files
------------

// File: rtl/mem2_stage.sv
// MEM2 pipeline stage: latches the MEM bundle, waits for the DCache load response,
// aligns/extends the load data and forms the write-back result for WB.
module mem2_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM2_Flush,
  input  logic        MEM2_Wr,
  input  logic [31:0] MEM_PC,
  input  logic [31:0] MEM_Instr,
  input  logic [31:0] MEM_ALUOut,
  input  logic [31:0] MEM_OutB,
  input  logic [1:0]  MEM_WbSel,
  input  logic [4:0]  MEM_Dst,
  input  logic [3:0]  MEM_RegsWrType,
  input  logic [2:0]  MEM_LoadType,
  input  logic        MEM_LoadReq,
  input  logic        DCache_rvalid,
  input  logic [31:0] DCache_rdata,
  output logic [31:0] MEM2_PC,
  output logic [31:0] MEM2_Instr,
  output logic [31:0] MEM2_OutB,
  output logic [1:0]  MEM2_WbSel,
  output logic [4:0]  MEM2_Dst,
  output logic [3:0]  MEM2_RegsWrType,
  output logic [31:0] MEM2_DMOut,
  output logic [31:0] MEM2_Result,
  output logic        MEM2_LoadStall
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_HELD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_pc, r_instr, r_aluout, r_outb, r_buf;
  logic [1:0]  r_wbsel;
  logic [4:0]  r_dst;
  logic [3:0]  r_rwt;
  logic [2:0]  r_ltype;
  logic        w_load;
  logic        w_capture;
  logic [1:0]  w_a;
  logic [31:0] w_dm;

  assign w_load = MEM2_Wr && !MEM2_Flush;

  always_ff @(posedge clk) begin
    if (rst || MEM2_Flush) begin
      r_pc     <= '0;
      r_instr  <= '0;
      r_aluout <= '0;
      r_outb   <= '0;
      r_wbsel  <= '0;
      r_dst    <= '0;
      r_rwt    <= '0;
      r_ltype  <= '0;
    end else if (MEM2_Wr) begin
      r_pc     <= MEM_PC;
      r_instr  <= MEM_Instr;
      r_aluout <= MEM_ALUOut;
      r_outb   <= MEM_OutB;
      r_wbsel  <= MEM_WbSel;
      r_dst    <= MEM_Dst;
      r_rwt    <= MEM_RegsWrType;
      r_ltype  <= MEM_LoadType;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
    end else begin
      r_state <= w_next;
      if (w_capture) r_buf <= DCache_rdata;
    end
  end

  // A flush in WAIT leaves the read in flight; DRAIN swallows its response.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    unique case (r_state)
      S_IDLE, S_HELD: begin
        if (w_load) w_next = MEM_LoadReq ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (MEM2_Flush) begin
          w_next = DCache_rvalid ? S_IDLE : S_DRAIN;
        end else if (DCache_rvalid) begin
          w_capture = 1'b1;
          w_next    = S_HELD;
        end
      end
      S_DRAIN: begin
        if (DCache_rvalid) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign MEM2_LoadStall = (r_state == S_WAIT) || (r_state == S_DRAIN);

  assign w_a = r_aluout[1:0];

  always_comb begin
    w_dm = r_buf;
    unique case (r_ltype)
      3'd0: w_dm = r_buf;
      3'd1: w_dm = {{24{r_buf[8*w_a+7]}}, r_buf[8*w_a +: 8]};
      3'd2: w_dm = {24'h0, r_buf[8*w_a +: 8]};
      3'd3: w_dm = w_a[1] ? {{16{r_buf[31]}}, r_buf[31:16]} : {{16{r_buf[15]}}, r_buf[15:0]};
      3'd4: w_dm = w_a[1] ? {16'h0, r_buf[31:16]} : {16'h0, r_buf[15:0]};
      3'd5: begin
        unique case (w_a)
          2'd0: w_dm = {r_buf[7:0],  r_outb[23:0]};
          2'd1: w_dm = {r_buf[15:0], r_outb[15:0]};
          2'd2: w_dm = {r_buf[23:0], r_outb[7:0]};
          2'd3: w_dm = r_buf;
          default: w_dm = r_buf;
        endcase
      end
      3'd6: begin
        unique case (w_a)
          2'd0: w_dm = r_buf;
          2'd1: w_dm = {r_outb[31:24], r_buf[31:8]};
          2'd2: w_dm = {r_outb[31:16], r_buf[31:16]};
          2'd3: w_dm = {r_outb[31:8],  r_buf[31:24]};
          default: w_dm = r_buf;
        endcase
      end
      default: w_dm = r_buf;
    endcase
  end

  always_comb begin
    MEM2_Result = r_pc + 32'd8;
    unique case (r_wbsel)
      2'd0: MEM2_Result = r_pc + 32'd8;
      2'd1: MEM2_Result = r_aluout;
      2'd2: MEM2_Result = r_outb;
      2'd3: MEM2_Result = w_dm;
      default: MEM2_Result = r_pc + 32'd8;
    endcase
  end

  assign MEM2_DMOut      = w_dm;
  assign MEM2_PC         = r_pc;
  assign MEM2_Instr      = r_instr;
  assign MEM2_OutB       = r_outb;
  assign MEM2_WbSel      = r_wbsel;
  assign MEM2_Dst        = r_dst;
  assign MEM2_RegsWrType = r_rwt;

endmodule
